// File: rtl/fb_ps2_kbd_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fb_ps2_kbd_rx                                                 |
// | Purpose  : PS/2 keyboard receiver. Deserialises 11-bit device-to-host   |
// |            frames, validates start/stop (and optionally parity), and    |
// |            buffers accepted scan codes in a small FIFO for the CPU.     |
// | Ports    : clk, rst_n      - system clock, async active-low reset       |
// |            ps2_clk/ps2_data - raw asynchronous PS/2 pins (idle high)    |
// |            rd               - pop FIFO head (single-cycle strobe)       |
// |            clr              - flush FIFO, clear sticky flags            |
// |            data             - FIFO head, zero-extended; 0 when empty    |
// |            av               - FIFO non-empty                            |
// |            overflow         - sticky, valid frame dropped (FIFO full)   |
// |            frame_err        - sticky, bad start/stop/parity or timeout  |
// | Options  : FB_KBD_PARITY_CHK_EN - enforce odd parity on received frames |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module fb_ps2_kbd_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd,
  input  logic        clr,
  output logic [31:0] data,
  output logic        av,
  output logic        overflow,
  output logic        frame_err
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_tw = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_aw:0]   c_ptr_one = (c_aw + 1)'(1);
  localparam logic [c_tw-1:0] c_to_one  = c_tw'(1);
  localparam logic [c_tw-1:0] c_to_max  = c_tw'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // Input conditioning: 2-flop synchronisers preset to the idle level.
  logic r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
  logic w_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

  // Frame datapath. The start bit is consumed in IDLE, so the shift register
  // only holds bits 1..10: [7:0]=code, [8]=parity, [9]=stop after the frame.
  logic [9:0]      r_shift;
  logic [3:0]      r_bitcnt;
  logic [c_tw-1:0] r_to_cnt;
  logic            w_timeout, w_chk_ok, w_chk_bad, w_frame_ok;

`ifdef FB_KBD_PARITY_CHK_EN
  assign w_frame_ok = r_shift[9] & (^r_shift[8:0]);
`else
  assign w_frame_ok = r_shift[9];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_chk_ok    = 1'b0;
    w_chk_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && !r_dat_s2) w_state_nxt = S_RECV;
      end
      S_RECV: begin
        if (w_fall) begin
          if (r_bitcnt == 4'd10) w_state_nxt = S_CHECK;
        end else if (r_to_cnt == c_to_max) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        w_chk_ok    = w_frame_ok;
        w_chk_bad   = ~w_frame_ok;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_to_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_to_cnt <= '0;
          if (w_fall && !r_dat_s2) r_bitcnt <= 4'd1;
        end
        S_RECV: begin
          if (w_fall) begin
            r_shift  <= {r_dat_s2, r_shift[9:1]};
            r_bitcnt <= r_bitcnt + 4'd1;
            r_to_cnt <= '0;
          end else if (w_timeout) begin
            r_bitcnt <= '0;
            r_to_cnt <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + c_to_one;
          end
        end
        default: begin
          r_bitcnt <= '0;
          r_to_cnt <= '0;
        end
      endcase
    end
  end

  // One-cycle staging between CHECK and the FIFO; the push, overflow and
  // frame_err all take effect on the edge after CHECK.
  logic       r_push, r_err_set;
  logic [7:0] r_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_push    <= 1'b0;
      r_err_set <= 1'b0;
      r_code    <= '0;
    end else begin
      r_push    <= w_chk_ok;
      r_err_set <= w_chk_bad | w_timeout;
      r_code    <= r_shift[7:0];
    end
  end

  // Scan-code FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [c_aw:0] r_wp, r_rp;
  logic w_empty, w_full, w_rd_eff, w_wr_eff;

  assign w_empty  = (r_wp == r_rp);
  assign w_full   = (r_wp[c_aw] != r_rp[c_aw]) &&
                    (r_wp[c_aw-1:0] == r_rp[c_aw-1:0]);
  assign w_rd_eff = rd & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_wr_eff = r_push & (~w_full | w_rd_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp      <= '0;
      r_rp      <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (clr) begin
      r_wp      <= '0;
      r_rp      <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_wr_eff) r_wp <= r_wp + c_ptr_one;
      if (w_rd_eff) r_rp <= r_rp + c_ptr_one;
      if (r_push && w_full && !w_rd_eff) overflow <= 1'b1;
      if (r_err_set) frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_eff && !clr) r_mem[r_wp[c_aw-1:0]] <= r_code;
  end

  assign av   = ~w_empty;
  assign data = w_empty ? 32'd0 : {24'd0, r_mem[r_rp[c_aw-1:0]]};

endmodule
`default_nettype wire

// File: tb/tb_fb_ps2_kbd_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fb_ps2_kbd_rx                                              |
// | Purpose  : Directed self-checking bench for fb_ps2_kbd_rx.               |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_fb_ps2_kbd_rx;

  localparam int HALF = 10;   // PS/2 half-period in clk cycles
  localparam int TO   = 100;  // TIMEOUT_CYCLES used for the DUT

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd       = 1'b0;
  logic        clr      = 1'b0;
  logic [31:0] data;
  logic        av, overflow, frame_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fb_ps2_kbd_rx #(
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd        (rd),
    .clr       (clr),
    .data      (data),
    .av        (av),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {stop, parity, code, start}; flip=1 produces a wrong parity bit.
  function automatic logic [10:0] mkframe(input logic [7:0] code, input logic flip);
    return {1'b1, (~^code) ^ flip, code, 1'b0};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      wait_clks(HALF);
      ps2_clk = 1'b0;
      wait_clks(HALF);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic send_frame(input logic [7:0] code);
    send_bits(mkframe(code, 1'b0), 0, 10);
  endtask

  task automatic pulse_rd();
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [7:0] code);
    check(tag, data, {24'd0, code});
    pulse_rd();
  endtask

  initial begin
    // ---- reset state
    wait_clks(3);
    check("rst_av", {31'd0, av}, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    wait_clks(3);

    // ---- 0x1C with exact push latency: stop bit driven by hand
    send_bits(mkframe(8'h1C, 1'b0), 0, 9);
    @(negedge clk);
    ps2_data = 1'b1;
    wait_clks(HALF);
    ps2_clk = 1'b0;                     // pin falls before edge N
    repeat (4) @(posedge clk);          // edges N..N+3
    #1 check("lat_av_n3", {31'd0, av}, 32'd0);
    @(posedge clk);                     // edge N+4
    #1 check("lat_av_n4", {31'd0, av}, 32'd1);
    check("lat_data", data, 32'h0000_001C);
    wait_clks(HALF);
    ps2_clk = 1'b1;
    wait_clks(HALF);
    check("1c_ferr", {31'd0, frame_err}, 32'd0);
    pulse_rd();
    check("1c_rd_av", {31'd0, av}, 32'd0);
    check("1c_rd_data", data, 32'd0);

    // ---- rd on empty FIFO is ignored
    pulse_rd();
    check("empty_rd_av", {31'd0, av}, 32'd0);
    check("empty_rd_data", data, 32'd0);

    // ---- wrong parity bit
    send_bits(mkframe(8'h1C, 1'b1), 0, 10);
`ifdef FB_KBD_PARITY_CHK_EN
    check("par_av", {31'd0, av}, 32'd0);
    check("par_ferr", {31'd0, frame_err}, 32'd1);
    pulse_clr();
    check("par_clr_ferr", {31'd0, frame_err}, 32'd0);
`else
    check("par_av", {31'd0, av}, 32'd1);
    check("par_data", data, 32'h0000_001C);
    check("par_ferr", {31'd0, frame_err}, 32'd0);
    pulse_rd();
    check("par_rd_av", {31'd0, av}, 32'd0);
`endif

    // ---- overflow: 9 frames into an 8-deep FIFO
    for (int k = 1; k <= 9; k++) send_frame(8'(k));
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_av", {31'd0, av}, 32'd1);
    for (int k = 1; k <= 8; k++) read_expect($sformatf("ovf_rd%0d", k), 8'(k));
    check("ovf_drain_av", {31'd0, av}, 32'd0);
    check("ovf_ferr", {31'd0, frame_err}, 32'd0);
    pulse_clr();
    check("ovf_clr", {31'd0, overflow}, 32'd0);

    // ---- full FIFO with rd coinciding with the 9th push
    for (int k = 1; k <= 8; k++) send_frame(8'(k));
    check("full_ovf_pre", {31'd0, overflow}, 32'd0);
    send_bits(mkframe(8'h09, 1'b0), 0, 9);
    @(negedge clk);
    ps2_data = 1'b1;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    repeat (4) @(posedge clk);          // through edge N+3
    @(negedge clk); rd = 1'b1;          // sampled at edge N+4 (push edge)
    @(negedge clk); rd = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
    wait_clks(HALF);
    check("coin_ovf", {31'd0, overflow}, 32'd0);
    for (int k = 2; k <= 9; k++) read_expect($sformatf("coin_rd%0d", k), 8'(k));
    check("coin_drain_av", {31'd0, av}, 32'd0);

    // ---- timeout on partial frame, then recovery
    send_bits(mkframe(8'h77, 1'b0), 0, 4);
    wait_clks(TO + 10);
    check("to_ferr", {31'd0, frame_err}, 32'd1);
    check("to_av", {31'd0, av}, 32'd0);
    pulse_clr();
    check("to_clr_ferr", {31'd0, frame_err}, 32'd0);
    send_frame(8'hF0);
    check("to_next_av", {31'd0, av}, 32'd1);
    check("to_next_ferr", {31'd0, frame_err}, 32'd0);
    read_expect("to_next_data", 8'hF0);

    // ---- reset mid-frame: remaining bits (all high) must not push
    send_frame(8'h33);
    check("mid_pre_av", {31'd0, av}, 32'd1);
    send_bits(mkframe(8'hC0, 1'b0), 0, 6);
    @(negedge clk); rst_n = 1'b0;
    wait_clks(3);
    check("mid_rst_av", {31'd0, av}, 32'd0);
    check("mid_rst_data", data, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    send_bits(mkframe(8'hC0, 1'b0), 7, 10);
    wait_clks(TO + 10);
    check("mid_tail_av", {31'd0, av}, 32'd0);
    check("mid_tail_ferr", {31'd0, frame_err}, 32'd0);
    send_frame(8'h5A);
    check("mid_next_av", {31'd0, av}, 32'd1);
    read_expect("mid_next_data", 8'h5A);
    check("mid_final_av", {31'd0, av}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
